// File: rtl/bombe_pkg.sv
// Shared constants, state encoding and types for the bombe rotor stepper.
package bombe_pkg;

  localparam int unsigned NUM_POS = 26;
  localparam int unsigned POS_W   = 5;
  localparam int unsigned CNT_W   = 15;

  localparam logic [CNT_W-1:0] LAST_COUNT = 15'd17575;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [1:0]       state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t CHECK = 2'd1;
  localparam state_t WAIT  = 2'd2;
  localparam state_t STEP  = 2'd3;

endpackage

// File: rtl/rotor_digit_0_25.sv
// One base-26 rotor position with load, carry-in increment and carry-out on wrap.
module rotor_digit_0_25
  import bombe_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic i_load,
  input  pos_t i_init,
  input  logic i_carry,
  output pos_t o_pos,
  output logic o_carry
);

  localparam pos_t MAX_POS = pos_t'(NUM_POS - 1);

  pos_t r_pos;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pos <= '0;
    end else if (i_load) begin
      r_pos <= (i_init > MAX_POS) ? '0 : i_init;
    end else if (i_carry) begin
      r_pos <= (r_pos == MAX_POS) ? '0 : r_pos + pos_t'(1);
    end
  end

  assign o_pos   = r_pos;
  assign o_carry = i_carry && (r_pos == MAX_POS);

endmodule

// File: rtl/bombe_rotor_stepper.sv
// Sweeps a three-rotor stack odometer-style, requesting one check per position.
module bombe_rotor_stepper
  import bombe_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [POS_W-1:0] init_l,
  input  logic [POS_W-1:0] init_m,
  input  logic [POS_W-1:0] init_r,
  input  logic             start,
  input  logic             abort,
  input  logic             check_valid,
  input  logic             check_hit,
  output logic [POS_W-1:0] pos_l,
  output logic [POS_W-1:0] pos_m,
  output logic [POS_W-1:0] pos_r,
  output logic             check_req,
  output logic             step_pulse,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             found
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic             r_check_req;
  logic             r_step_pulse;
  logic             r_busy;
  logic             r_done;
  logic             r_found;

  logic w_load;
  logic w_start;
  logic w_abort;
  logic w_verdict;
  logic w_finish;
  logic w_step;
  logic w_carry_r;
  logic w_carry_m;
  logic w_carry_l;

  assign w_load    = (r_state == IDLE) && load;
  assign w_start   = (r_state == IDLE) && !load && start;
  assign w_abort   = (r_state != IDLE) && abort;
  // A verdict arriving alongside check_req (CHECK) is taken as the answer to it.
  assign w_verdict = ((r_state == CHECK) || (r_state == WAIT)) && check_valid && !abort;
  assign w_finish  = w_verdict && (check_hit || (r_count == LAST_COUNT));
  assign w_step    = (r_state == STEP) && !abort;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = CHECK;
      CHECK:   w_state_nxt = w_abort ? IDLE : (w_finish ? IDLE : (w_verdict ? STEP : WAIT));
      WAIT:    w_state_nxt = w_abort ? IDLE : (w_finish ? IDLE : (w_verdict ? STEP : WAIT));
      STEP:    w_state_nxt = w_abort ? IDLE : CHECK;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_check_req  <= 1'b0;
      r_step_pulse <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_found      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_check_req  <= (w_state_nxt == CHECK);
      r_step_pulse <= (w_state_nxt == STEP);
      r_busy       <= (w_state_nxt == CHECK) || (w_state_nxt == STEP);
      if (w_start) begin
        r_count <= '0;
        r_done  <= 1'b0;
        r_found <= 1'b0;
      end
      if (w_abort) begin
        r_done  <= 1'b0;
        r_found <= 1'b0;
      end
      if (w_step) r_count <= r_count + CNT_W'(1);
      if (w_finish) begin
        r_done  <= 1'b1;
        r_found <= check_hit;
      end
    end
  end

  rotor_digit_0_25 u_rotor_r (
    .clk     (clk),
    .resetn  (resetn),
    .i_load  (w_load),
    .i_init  (init_r),
    .i_carry (w_step),
    .o_pos   (pos_r),
    .o_carry (w_carry_r)
  );

  rotor_digit_0_25 u_rotor_m (
    .clk     (clk),
    .resetn  (resetn),
    .i_load  (w_load),
    .i_init  (init_m),
    .i_carry (w_carry_r),
    .o_pos   (pos_m),
    .o_carry (w_carry_m)
  );

  rotor_digit_0_25 u_rotor_l (
    .clk     (clk),
    .resetn  (resetn),
    .i_load  (w_load),
    .i_init  (init_l),
    .i_carry (w_carry_m),
    .o_pos   (pos_l),
    .o_carry (w_carry_l)
  );

  assign check_req  = r_check_req;
  assign step_pulse = r_step_pulse;
  assign count      = r_count;
  assign busy       = r_busy;
  assign done       = r_done;
  assign found      = r_found;

endmodule

// File: tb/tb_bombe_rotor_stepper.sv
// Directed bench for bombe_rotor_stepper: reset, carries, priority, abort and a full sweep.
module tb_bombe_rotor_stepper;

  logic        clk = 1'b0;
  logic        resetn;
  logic        load;
  logic [4:0]  init_l, init_m, init_r;
  logic        start;
  logic        abort;
  logic        check_valid;
  logic        check_hit;
  logic [4:0]  pos_l, pos_m, pos_r;
  logic        check_req;
  logic        step_pulse;
  logic [14:0] count;
  logic        busy;
  logic        done;
  logic        found;

  int errors = 0;
  int checks = 0;
  int n_req  = 0;
  int n_step = 0;

  bombe_rotor_stepper dut (
    .clk         (clk),
    .resetn      (resetn),
    .load        (load),
    .init_l      (init_l),
    .init_m      (init_m),
    .init_r      (init_r),
    .start       (start),
    .abort       (abort),
    .check_valid (check_valid),
    .check_hit   (check_hit),
    .pos_l       (pos_l),
    .pos_m       (pos_m),
    .pos_r       (pos_r),
    .check_req   (check_req),
    .step_pulse  (step_pulse),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .found       (found)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (check_req)  n_req++;
    if (step_pulse) n_step++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
    init_l = l; init_m = m; init_r = r; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    do_load(5'd5, 5'd6, 5'd7);
    start = 1'b1; tick(); start = 1'b0;
    check_valid = 1'b1; check_hit = 1'b0;
    repeat (5) tick();
    resetn = 1'b0; load = 1'b1; start = 1'b1;
    init_l = 5'd9; init_m = 5'd9; init_r = 5'd9;
    tick(); tick();
    resetn = 1'b1; load = 1'b0; start = 1'b0; check_valid = 1'b0;
    checks++;
    if ({pos_l, pos_m, pos_r} !== 15'd0) begin
      errors++; $display("FAIL reset_pos: got %0d,%0d,%0d expected 0,0,0", pos_l, pos_m, pos_r);
    end
    checks++;
    if ({check_req, step_pulse, busy, done, found} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got req=%0b step=%0b busy=%0b done=%0b found=%0b expected all 0",
                         check_req, step_pulse, busy, done, found);
    end
    checks++;
    if (count !== 15'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", count);
    end
    tick();
    checks++;
    if (check_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got req=%0b busy=%0b expected 0,0", check_req, busy);
    end
  endtask

  task automatic test_hit_second();
    int req0, step0;
    do_load(5'd0, 5'd0, 5'd25);
    req0 = n_req; step0 = n_step;
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (check_req !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL hit_first_req: got req=%0b busy=%0b expected 1,1", check_req, busy);
    end
    check_valid = 1'b1; check_hit = 1'b0; tick(); check_valid = 1'b0;
    tick();
    checks++;
    if ({pos_l, pos_m, pos_r} !== {5'd0, 5'd1, 5'd0}) begin
      errors++; $display("FAIL hit_step_pos: got %0d,%0d,%0d expected 0,1,0", pos_l, pos_m, pos_r);
    end
    tick();
    checks++;
    if (check_req !== 1'b0 || {pos_l, pos_m, pos_r} !== {5'd0, 5'd1, 5'd0}) begin
      errors++; $display("FAIL hit_wait_hold: got req=%0b pos=%0d,%0d,%0d expected 0 and 0,1,0",
                         check_req, pos_l, pos_m, pos_r);
    end
    check_valid = 1'b1; check_hit = 1'b1; tick(); check_valid = 1'b0; check_hit = 1'b0;
    checks++;
    if (found !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || count !== 15'd1) begin
      errors++; $display("FAIL hit_result: got found=%0b done=%0b busy=%0b count=%0d expected 1,1,0,1",
                         found, done, busy, count);
    end
    checks++;
    if ({pos_l, pos_m, pos_r} !== {5'd0, 5'd1, 5'd0}) begin
      errors++; $display("FAIL hit_pos: got %0d,%0d,%0d expected 0,1,0", pos_l, pos_m, pos_r);
    end
    checks++;
    if (n_req - req0 != 2 || n_step - step0 != 1) begin
      errors++; $display("FAIL hit_pulses: got req=%0d step=%0d expected 2,1", n_req - req0, n_step - step0);
    end
  endtask

  task automatic test_double_carry();
    do_load(5'd25, 5'd25, 5'd25);
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (done !== 1'b0 || found !== 1'b0) begin
      errors++; $display("FAIL carry_start_clear: got done=%0b found=%0b expected 0,0", done, found);
    end
    check_valid = 1'b1; check_hit = 1'b0; tick(); check_valid = 1'b0;
    checks++;
    if (step_pulse !== 1'b1 || check_req !== 1'b0 || {pos_l, pos_m, pos_r} !== {5'd25, 5'd25, 5'd25}) begin
      errors++; $display("FAIL carry_step_cycle: got step=%0b req=%0b pos=%0d,%0d,%0d expected 1,0,25,25,25",
                         step_pulse, check_req, pos_l, pos_m, pos_r);
    end
    tick();
    checks++;
    if ({pos_l, pos_m, pos_r} !== 15'd0 || count !== 15'd1 || check_req !== 1'b1 || step_pulse !== 1'b0) begin
      errors++; $display("FAIL carry_wrap: got pos=%0d,%0d,%0d count=%0d req=%0b step=%0b expected 0,0,0,1,1,0",
                         pos_l, pos_m, pos_r, count, check_req, step_pulse);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL carry_abort_busy: got %0b expected 0", busy);
    end
  endtask

  task automatic test_load_priority();
    init_l = 5'd30; init_m = 5'd26; init_r = 5'd4;
    load = 1'b1; start = 1'b1; tick(); load = 1'b0; start = 1'b0;
    checks++;
    if ({pos_l, pos_m, pos_r} !== {5'd0, 5'd0, 5'd4} || check_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL load_prio: got pos=%0d,%0d,%0d req=%0b busy=%0b expected 0,0,4,0,0",
                         pos_l, pos_m, pos_r, check_req, busy);
    end
    tick();
    checks++;
    if (check_req !== 1'b0) begin
      errors++; $display("FAIL load_prio_nostart: got req=%0b expected 0", check_req);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (check_req !== 1'b1) begin
      errors++; $display("FAIL start_latency: got req=%0b expected 1", check_req);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_abort();
    int cyc;
    do_load(5'd0, 5'd0, 5'd0);
    start = 1'b1; tick(); start = 1'b0;
    check_valid = 1'b1; check_hit = 1'b0;
    cyc = 0;
    while (count != 15'd10 && cyc < 100) begin
      tick(); cyc++;
    end
    checks++;
    if (count !== 15'd10 || check_req !== 1'b1) begin
      errors++; $display("FAIL abort_reach10: got count=%0d req=%0b expected 10,1", count, check_req);
    end
    abort = 1'b1; check_hit = 1'b1; tick();
    abort = 1'b0; check_valid = 1'b0; check_hit = 1'b0;
    checks++;
    if (found !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || count !== 15'd10) begin
      errors++; $display("FAIL abort_state: got found=%0b done=%0b busy=%0b count=%0d expected 0,0,0,10",
                         found, done, busy, count);
    end
    tick();
    checks++;
    if ({pos_l, pos_m, pos_r} !== {5'd0, 5'd0, 5'd10} || check_req !== 1'b0) begin
      errors++; $display("FAIL abort_pos: got pos=%0d,%0d,%0d req=%0b expected 0,0,10,0",
                         pos_l, pos_m, pos_r, check_req);
    end
  endtask

  task automatic test_full_sweep();
    int req0, cyc;
    do_load(5'd3, 5'd7, 5'd11);
    req0 = n_req;
    check_valid = 1'b1; check_hit = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40000) begin
      tick(); cyc++;
    end
    check_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || found !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL sweep_done: got done=%0b found=%0b busy=%0b expected 1,0,0", done, found, busy);
    end
    checks++;
    if (count !== 15'd17575) begin
      errors++; $display("FAIL sweep_count: got %0d expected 17575", count);
    end
    checks++;
    if (n_req - req0 != 17576) begin
      errors++; $display("FAIL sweep_reqs: got %0d expected 17576", n_req - req0);
    end
    checks++;
    if ({pos_l, pos_m, pos_r} !== {5'd3, 5'd7, 5'd10}) begin
      errors++; $display("FAIL sweep_pos: got %0d,%0d,%0d expected 3,7,10", pos_l, pos_m, pos_r);
    end
  endtask

  initial begin
    resetn = 1'b0; load = 1'b0; start = 1'b0; abort = 1'b0;
    check_valid = 1'b0; check_hit = 1'b0;
    init_l = '0; init_m = '0; init_r = '0;
    tick(); tick();
    resetn = 1'b1;
    test_reset();
    test_hit_second();
    test_double_carry();
    test_load_priority();
    test_abort();
    test_full_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bombe_rotor_stepper.md
Name: bombe_rotor_stepper

Overview:
- Sequencing controller for a three-rotor bombe stack (left, middle, right), each rotor position 0..25.
- Loads start positions, then steps odometer-style: right is the fast rotor and carries into middle, middle carries into left.
- After every position it requests one check from the downstream menu/contradiction checker and waits for the verdict.
- Stops on the first hit or after all 17576 positions; sits between host control and the rotor datapaths, whose position inputs it drives.

Parameters:
- NUM_POS, 26, positions per rotor; carry out of a rotor occurs on NUM_POS-1 -> 0.
- POS_W, 5, rotor position width.
- CNT_W, 15, width of the step counter; must hold NUM_POS^3-1 = 17575.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- resetn  in  1  synchronous active-low reset.
- load  in  1  latch init_l/init_m/init_r into positions; acts only in IDLE.
- init_l, init_m, init_r  in  POS_W each  start positions.
- start  in  1  begin a sweep; acts only in IDLE.
- abort  in  1  cancel the sweep in progress.
- check_valid  in  1  checker verdict strobe.
- check_hit  in  1  verdict value, qualified by check_valid.
- pos_l, pos_m, pos_r  out  POS_W each  current rotor positions, registered.
- check_req  out  1  one-cycle pulse requesting a check of the current positions.
- step_pulse  out  1  high for exactly the cycle in which the positions change by a step.
- count  out  CNT_W  number of steps taken in this sweep.
- busy  out  1  high in CHECK and STEP.
- done  out  1  sweep finished; sticky until next start or reset.
- found  out  1  sweep ended on a hit; sticky like done.

Behaviour:
- Reset (resetn=0 at posedge): state IDLE; all pos=0; count=0; check_req=0; step_pulse=0; busy=0; done=0; found=0.
- Reset mid-sweep behaves the same; any pending check is abandoned.
- States: IDLE, CHECK, WAIT, STEP.
- IDLE, load=1:
  - Each pos takes its init value on the next edge.
  - An init value greater than 25 loads as 0.
  - load has priority over start in the same cycle; start is ignored.
- IDLE, start=1 (load=0):
  - Go to CHECK; count=0, done=0, found=0, busy=1 from the next cycle.
- CHECK (exactly one cycle): check_req=1; go to WAIT.
  - Latency: start sampled at edge N gives check_req high in cycle N+1.
- WAIT: hold positions until check_valid=1.
  - check_hit=1: found=1, done=1, go to IDLE; positions hold the hit value.
  - check_hit=0 and count==17575: done=1, found=0, go to IDLE.
  - Otherwise go to STEP.
  - A check_valid arriving in the same cycle as check_req counts as the verdict for that request.
  - check_valid in IDLE or STEP is ignored.
- STEP (exactly one cycle): step_pulse=1; count+=1; go to CHECK.
  - pos_r increments; 25 wraps to 0 with a carry into pos_m.
  - pos_m increments on carry in; 25 wraps to 0 with a carry into pos_l.
  - pos_l increments on carry in; 25 wraps to 0 with no further effect.
  - Positions are visible the cycle after STEP, together with check_req.
- abort=1 in CHECK, WAIT or STEP: go to IDLE next edge; positions and count hold; done=0, found=0; busy=0.
  - abort beats check_valid in the same cycle.
  - abort in IDLE has no effect.
- A full sweep visits every one of the 17576 positions exactly once and returns to the start position only if it steps past the last one, which it never does (it stops at count 17575).
- All outputs are registered; no combinational path from input to output.

Decomposition:
- Shared package bombe_pkg holds:
  - constants NUM_POS, POS_W, CNT_W, LAST_COUNT=17575;
  - the state encoding IDLE/CHECK/WAIT/STEP as localparams;
  - the rotor position width typedef.
- Sub-module rotor_digit_0_25:
  - one position register with load (out-of-range loads as 0), increment-on-carry-in, and carry_out on 25->0;
  - instantiated three times and chained r -> m -> l;
  - the FSM and counter stay in the top.

Test Plan:
- Reset with resetn=0 for 2 cycles after random activity -> all outputs 0 and state IDLE; load+start held during reset are ignored.
- load 0,0,25 then start; hit returned on the 2nd check -> positions 0,1,0; count=1; found=1, done=1; exactly 2 check_req and 1 step_pulse.
- load 25,25,25, start, miss on the 1st verdict -> positions 0,0,0 after one STEP (double carry plus left wrap).
- load 3,7,11, start, always miss -> done=1, found=0, count=17575, 17576 check_req pulses, final positions one step before 3,7,11, i.e. 3,7,10.
- Run 10 steps then abort asserted together with check_valid/check_hit=1 -> IDLE, found=0, done=0, count=10, positions unchanged.
- In IDLE: load=1 and start=1 in the same cycle with init 30,26,4 -> positions 0,0,4, no check_req; a separate start then gives check_req one cycle later.
